// File: rtl/spi_pkg.sv
// Shared definitions for the SPI bus arbiter: FSM state encoding and SPI mode constants.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACTIVE = 3'd2,
        SHIFT  = 3'd3,
        HOLD   = 3'd4
    } state_e;

    // Mode 0: SCK idles low, data launched on falling edge, sampled on rising edge.
    localparam logic        SPI_CPOL = 1'b0;
    localparam int unsigned SPI_BITS = 8;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCK divider and bit counter; emits single-cycle ticks on the clk_i edge where SCK rises or falls.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic en_i,
    output logic sck_o,
    output logic rise_o,
    output logic fall_o,
    output logic last_o
);

    logic [7:0] div_q, div_d;
    logic [2:0] bit_q, bit_d;
    logic       sck_q, sck_d;
    logic       div_end;

    assign div_end = en_i && (div_q == 8'(CLK_DIV - 1));
    assign rise_o  = div_end && (sck_q == SPI_CPOL);
    assign fall_o  = div_end && (sck_q != SPI_CPOL);
    assign last_o  = fall_o && (bit_q == 3'(SPI_BITS - 1));
    assign sck_o   = sck_q;

    always_comb begin
        div_d = div_q;
        bit_d = bit_q;
        sck_d = sck_q;
        if (!en_i) begin
            div_d = '0;
            bit_d = '0;
            sck_d = SPI_CPOL;
        end else if (div_end) begin
            div_d = '0;
            sck_d = ~sck_q;
            if (fall_o) begin
                bit_d = bit_q + 3'd1;
            end
        end else begin
            div_d = div_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            div_q <= '0;
            bit_q <= '0;
            sck_q <= SPI_CPOL;
        end else begin
            div_q <= div_d;
            bit_q <= bit_d;
            sck_q <= sck_d;
        end
    end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Two-requester round-robin arbiter owning one SPI mode-0 master; each session selects one
// of two chip selects and carries any number of 8-bit full-duplex transfers.
module spi_bus_arbiter
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic [1:0]      req_i,
    input  logic [1:0]      sel_i,
    output logic [1:0]      gnt_o,
    input  logic [1:0]      tx_valid_i,
    input  logic [1:0][7:0] tx_data_i,
    output logic [1:0]      tx_ready_o,
    output logic [1:0]      rx_valid_o,
    output logic [7:0]      rx_data_o,
    output logic            spi_clk_o,
    output logic            spi_sdo_o,
    input  logic            spi_sdi_i,
    output logic [1:0]      spi_csn_o
);

    state_e     state_q, state_d;
    logic       owner_q, owner_d;
    logic       sel_q, sel_d;
    logic       last_q, last_d;
    logic [7:0] wait_q, wait_d;
    logic [7:0] tx_sh_q, tx_sh_d;
    logic [7:0] rx_sh_q, rx_sh_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic [1:0] rx_valid_q, rx_valid_d;

    logic       winner;
    logic       wait_end;
    logic       in_session;
    logic       sck_rise, sck_fall, byte_last;

    spi_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .en_i   (state_q == SHIFT),
        .sck_o  (spi_clk_o),
        .rise_o (sck_rise),
        .fall_o (sck_fall),
        .last_o (byte_last)
    );

    // On a tie the requester that was not served last wins.
    assign winner   = (req_i == 2'b11) ? ~last_q : req_i[1];
    assign wait_end = (wait_q == 8'(CLK_DIV - 1));

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        sel_d      = sel_q;
        last_d     = last_q;
        wait_d     = wait_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = '0;
        unique case (state_q)
            IDLE: begin
                wait_d = '0;
                if (|req_i) begin
                    owner_d = winner;
                    sel_d   = sel_i[winner];
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (wait_end) begin
                    wait_d  = '0;
                    state_d = ACTIVE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ACTIVE: begin
                if (tx_valid_i[owner_q]) begin
                    tx_sh_d = tx_data_i[owner_q];
                    state_d = SHIFT;
                end else if (!req_i[owner_q]) begin
                    wait_d  = '0;
                    state_d = HOLD;
                end
            end
            SHIFT: begin
                if (sck_rise) begin
                    rx_sh_d = {rx_sh_q[6:0], spi_sdi_i};
                end
                if (sck_fall) begin
                    tx_sh_d = {tx_sh_q[6:0], 1'b0};
                end
                // A dropped request is only honoured back in ACTIVE, so the byte always completes.
                if (byte_last) begin
                    rx_data_d  = rx_sh_q;
                    rx_valid_d = onehot2(owner_q);
                    state_d    = ACTIVE;
                end
            end
            HOLD: begin
                if (wait_end) begin
                    wait_d  = '0;
                    last_d  = owner_q;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            sel_q      <= 1'b0;
            last_q     <= 1'b1;
            wait_q     <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            wait_q     <= wait_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign in_session = (state_q != IDLE);
    assign gnt_o      = in_session ? onehot2(owner_q) : 2'b00;
    assign spi_csn_o  = in_session ? ~onehot2(sel_q) : 2'b11;
    assign tx_ready_o = (state_q == ACTIVE) ? onehot2(owner_q) : 2'b00;
    assign spi_sdo_o  = (state_q == SHIFT) && tx_sh_q[7];
    assign rx_valid_o = rx_valid_q;
    assign rx_data_o  = rx_data_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed and randomized sessions against a behavioural arbiter/slave model with CLK_DIV=2.
module tb_spi_bus_arbiter;

    localparam int unsigned D      = 2;
    localparam int          BYTE_T = 16 * D;

    logic            clk_i = 1'b0;
    logic            rstn_i;
    logic [1:0]      req_i, sel_i, tx_valid_i;
    logic [1:0][7:0] tx_data_i;
    logic [1:0]      gnt_o, tx_ready_o, rx_valid_o, spi_csn_o;
    logic [7:0]      rx_data_o;
    logic            spi_clk_o, spi_sdo_o, spi_sdi_i;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rises    = 0;
    int rx_n     = 0;
    int csn_bad  = 0;
    int last_m   = 1;

    logic [7:0] rx_seen;
    logic [1:0] rx_who;
    logic [1:0] rx_prev   = 2'b00;
    logic       sck_seen  = 1'b0;
    logic       csn_watch = 1'b0;
    logic [1:0] csn_exp   = 2'b11;

    // Slave model: loopback or a fixed byte shifted out MSB first, advancing after each SCK fall.
    logic       loop_mode = 1'b1;
    logic [7:0] s_byte    = 8'h00;
    logic [2:0] s_bit     = 3'd0;
    logic       s_sck_q   = 1'b0;

    spi_bus_arbiter #(
        .CLK_DIV(D)
    ) dut (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .req_i      (req_i),
        .sel_i      (sel_i),
        .gnt_o      (gnt_o),
        .tx_valid_i (tx_valid_i),
        .tx_data_i  (tx_data_i),
        .tx_ready_o (tx_ready_o),
        .rx_valid_o (rx_valid_o),
        .rx_data_o  (rx_data_o),
        .spi_clk_o  (spi_clk_o),
        .spi_sdo_o  (spi_sdo_o),
        .spi_sdi_i  (spi_sdi_i),
        .spi_csn_o  (spi_csn_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        s_sck_q <= spi_clk_o;
        if (spi_csn_o == 2'b11) s_bit <= 3'd0;
        else if (s_sck_q && !spi_clk_o) s_bit <= s_bit + 3'd1;
    end

    assign spi_sdi_i = loop_mode ? spi_sdo_o : s_byte[3'd7 - s_bit];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [1:0] rq, input int last);
        if (rq == 2'b11) return 1 - last;
        return rq[1] ? 1 : 0;
    endfunction

    function automatic logic [1:0] csn_for(input logic s);
        return s ? 2'b01 : 2'b10;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
        chk("csn_not_both_low", 32'(spi_csn_o == 2'b00), 0);
        chk("sck_low_when_idle", 32'((spi_csn_o == 2'b11) && spi_clk_o), 0);
        chk("sdo_low_when_idle", 32'((spi_csn_o == 2'b11) && spi_sdo_o), 0);
        chk("ready_low_when_idle", 32'((spi_csn_o == 2'b11) && (|tx_ready_o)), 0);
        chk("gnt_onehot", 32'($countones(gnt_o) > 1), 0);
        chk("rx_single_cycle", 32'((|rx_valid_o) && (|rx_prev)), 0);
        if (spi_clk_o && !sck_seen) rises++;
        sck_seen = spi_clk_o;
        if (|rx_valid_o) begin
            rx_n++;
            rx_seen = rx_data_o;
            rx_who  = rx_valid_o;
        end
        rx_prev = rx_valid_o;
        if (csn_watch && spi_csn_o !== csn_exp) csn_bad++;
    endtask

    task automatic do_reset();
        req_i      = 2'b00;
        tx_valid_i = 2'b00;
        rstn_i     = 1'b0;
        tick();
        chk("rst_gnt", 32'(gnt_o), 0);
        chk("rst_csn", 32'(spi_csn_o), 32'h3);
        chk("rst_sck", 32'(spi_clk_o), 0);
        chk("rst_sdo", 32'(spi_sdo_o), 0);
        chk("rst_ready", 32'(tx_ready_o), 0);
        chk("rst_rx_valid", 32'(rx_valid_o), 0);
        chk("rst_rx_data", 32'(rx_data_o), 0);
        tick();
        rstn_i = 1'b1;
        tick();
        csn_watch = 1'b0;
        last_m    = 1;
    endtask

    task automatic wait_ready(input int r, output int n);
        n = 0;
        while (tx_ready_o[r] !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
    endtask

    task automatic open_session(input logic [1:0] rq, input logic [1:0] sl, output int w);
        int n;
        w     = pick(rq, last_m);
        req_i = rq;
        sel_i = sl;
        tick();
        chk("grant", 32'(gnt_o), 32'(1 << w));
        chk("csn_select", 32'(spi_csn_o), 32'(csn_for(sl[w])));
        csn_exp   = csn_for(sl[w]);
        csn_bad   = 0;
        csn_watch = 1'b1;
        wait_ready(w, n);
        chk("setup_cycles", n, D);
        chk("ready_owner", 32'(tx_ready_o), 32'(1 << w));
    endtask

    task automatic send_byte(input int r, input logic [7:0] d, input logic [7:0] exp_rx);
        int n, r0, st;
        tx_valid_i[r] = 1'b1;
        tx_data_i[r]  = d;
        r0 = rises;
        st = rx_n;
        tick();
        n = 1;
        tx_valid_i[r] = 1'b0;
        while (rx_n == st && n < 200) begin
            chk("ready_low_in_shift", 32'(tx_ready_o), 0);
            tick();
            n++;
        end
        chk("byte_latency", n, BYTE_T + 1);
        chk("sck_pulses", rises - r0, 8);
        chk("rx_data", 32'(rx_seen), 32'(exp_rx));
        chk("rx_target", 32'(rx_who), 32'(1 << r));
    endtask

    task automatic close_session(input int w);
        req_i      = 2'b00;
        tx_valid_i = 2'b00;
        chk("csn_steady", csn_bad, 0);
        csn_watch = 1'b0;
        for (int i = 0; i < int'(D); i++) begin
            tick();
            chk("hold_csn", 32'(spi_csn_o), 32'(csn_exp));
            chk("hold_gnt", 32'(gnt_o), 32'(1 << w));
        end
        tick();
        chk("idle_csn", 32'(spi_csn_o), 32'h3);
        chk("idle_gnt", 32'(gnt_o), 0);
        last_m = w;
    endtask

    initial begin
        logic [1:0] rq, sl;
        logic [7:0] d, ex;
        int w, n, nb, r0, st, p_cyc;

        req_i      = 2'b00;
        sel_i      = 2'b00;
        tx_valid_i = 2'b00;
        tx_data_i  = '0;
        rstn_i     = 1'b0;
        do_reset();

        // Single byte loopback on the flash select.
        loop_mode = 1'b1;
        open_session(2'b01, 2'b00, w);
        send_byte(w, 8'hA5, 8'hA5);
        close_session(w);

        // Simultaneous requests right after reset; r0 first, r1 after one idle cycle.
        do_reset();
        open_session(2'b11, 2'b10, w);
        chk("tie_first_winner", w, 0);
        csn_watch = 1'b0;
        req_i = 2'b10;
        for (int i = 0; i < int'(D) + 1; i++) tick();
        chk("gap_gnt", 32'(gnt_o), 0);
        chk("gap_csn", 32'(spi_csn_o), 32'h3);
        tick();
        chk("second_gnt", 32'(gnt_o), 32'h2);
        chk("second_csn", 32'(spi_csn_o), 32'h1);
        last_m  = 0;
        w       = 1;
        csn_exp = 2'b01;
        csn_bad = 0;
        csn_watch = 1'b1;
        wait_ready(1, n);
        chk("second_setup", n, D);
        d = 8'($urandom);
        send_byte(1, d, d);
        close_session(1);

        // Three back-to-back bytes with the slave returning 0x3C.
        loop_mode = 1'b0;
        s_byte    = 8'h3C;
        open_session(2'b10, 2'b10, w);
        tx_valid_i[1] = 1'b1;
        tx_data_i[1]  = 8'hFF;
        st    = rx_n;
        p_cyc = cyc;
        n     = 0;
        while (rx_n - st < 3 && n < 400) begin
            tick();
            n++;
            if (|rx_valid_o) begin
                chk("b2b_data", 32'(rx_data_o), 32'h3C);
                chk("b2b_target", 32'(rx_valid_o), 32'h2);
                chk("b2b_spacing", cyc - p_cyc, BYTE_T + 1);
                p_cyc = cyc;
            end
        end
        chk("b2b_count", rx_n - st, 3);
        close_session(1);

        // Request dropped mid-byte and sel_i toggled; byte must finish on the original select.
        loop_mode = 1'b1;
        open_session(2'b01, 2'b00, w);
        tx_valid_i[0] = 1'b1;
        tx_data_i[0]  = 8'h81;
        r0 = rises;
        st = rx_n;
        tick();
        n = 1;
        tx_valid_i[0] = 1'b0;
        while (rises - r0 < 4 && n < 200) begin
            tick();
            n++;
        end
        req_i = 2'b00;
        sel_i = 2'b11;
        while (rx_n == st && n < 200) begin
            tick();
            n++;
        end
        chk("drop_latency", n, BYTE_T + 1);
        chk("drop_rx_data", 32'(rx_seen), 32'h81);
        chk("drop_rx_target", 32'(rx_who), 32'h1);
        close_session(0);
        sel_i = 2'b00;

        // Randomized sessions; odd iterations force a tie to exercise round robin.
        for (int k = 0; k < 6; k++) begin
            rq = (k % 2 == 1) ? 2'b11 : 2'($urandom_range(1, 3));
            sl = 2'($urandom);
            loop_mode = 1'($urandom);
            s_byte    = 8'($urandom);
            open_session(rq, sl, w);
            nb = int'($urandom_range(1, 2));
            for (int b = 0; b < nb; b++) begin
                d  = 8'($urandom);
                ex = loop_mode ? d : s_byte;
                send_byte(w, d, ex);
            end
            close_session(w);
        end

        // Reset during the byte: immediate idle bus and no receive pulse afterwards.
        loop_mode = 1'b1;
        open_session(2'b01, 2'b00, w);
        tx_valid_i[0] = 1'b1;
        tx_data_i[0]  = 8'($urandom);
        r0 = rises;
        tick();
        tx_valid_i[0] = 1'b0;
        n = 0;
        while (rises - r0 < 3 && n < 200) begin
            tick();
            n++;
        end
        chk("abort_reached_bit5", rises - r0, 3);
        csn_watch = 1'b0;
        rstn_i = 1'b0;
        st = rx_n;
        tick();
        chk("abort_csn", 32'(spi_csn_o), 32'h3);
        chk("abort_sck", 32'(spi_clk_o), 0);
        chk("abort_gnt", 32'(gnt_o), 0);
        chk("abort_rx_valid", 32'(rx_valid_o), 0);
        rstn_i = 1'b1;
        req_i  = 2'b00;
        last_m = 1;
        for (int i = 0; i < BYTE_T + 4; i++) tick();
        chk("abort_no_rx", rx_n - st, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_bus_arbiter.md
SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, SCK half-period in clk_i cycles (legal 1..255).
REQ-002 SHALL have port clk_i  in  1  system clock; all logic rises on clk_i.
REQ-003 SHALL have port rstn_i  in  1  reset: one clock; reset is synchronous and active-low.
REQ-004 SHALL have port req_i  in  2  per requester r: session request, held for whole session.
REQ-005 SHALL have port sel_i  in  2  per requester: target, 0=flash (csn[0]), 1=SD card (csn[1]).
REQ-006 SHALL have port gnt_o  out  2  per requester: session granted, one-hot or zero.
REQ-007 SHALL have ports tx_valid_i in 2, tx_data_i in 2x8, tx_ready_o out 2: per-requester byte-transmit handshake.
REQ-008 SHALL have ports rx_valid_o out 2, rx_data_o out 8 (shared): received byte, one-cycle pulse to granted requester.
REQ-009 SHALL have ports spi_clk_o out 1, spi_sdo_o out 1 (MOSI), spi_sdi_i in 1 (MISO), spi_csn_o out 2 (active-low); these drive the SPI wiring block's host side.

Function
REQ-010 SHALL implement SPI mode 0, MSB first, 8-bit transfers; byte time 16*CLK_DIV cycles.
REQ-011 SHALL use FSM states IDLE, SETUP, ACTIVE, SHIFT, HOLD.
REQ-012 IDLE: csn=11, sck=0, gnt=00; any req_i set -> grant winner, latch its sel_i, go SETUP next cycle.
REQ-013 Arbitration SHALL be round-robin: with both requesting, requester other than last granted wins; last-granted pointer resets to 1 (so requester 0 wins first tie).
REQ-014 SETUP: gnt_o[winner]=1, csn[latched sel] low; after CLK_DIV cycles -> ACTIVE.
REQ-015 ACTIVE: tx_ready_o[granted]=1 (other requester 0); tx_valid&tx_ready -> load shift register with tx_data, go SHIFT; else req_i[granted]=0 -> HOLD.
REQ-016 SHIFT: sdo=shift MSB while sck low; after CLK_DIV cycles sck rises and spi_sdi_i is sampled; after further CLK_DIV cycles sck falls and register shifts left; repeated 8 times.
REQ-017 After 8th falling edge SHALL pulse rx_valid_o[granted] one cycle with rx_data_o = sampled byte (first sample in bit 7), return ACTIVE.
REQ-018 Back-to-back bytes: tx_valid held high in ACTIVE SHALL accept next byte on first ACTIVE cycle, giving one non-shifting cycle between bytes.
REQ-019 req_i drop during SHIFT SHALL NOT abort; byte completes, rx pulse issued, then HOLD.
REQ-020 HOLD: csn stays low CLK_DIV cycles, then csn=11, gnt=00, update last-granted pointer, go IDLE; at least one IDLE cycle between sessions.
REQ-021 sel_i and non-granted tx_valid_i SHALL be ignored during a session; tx_ready_o SHALL be 0 outside ACTIVE.
REQ-022 spi_csn_o SHALL never have both bits low; spi_clk_o SHALL be 0 whenever csn=11.
REQ-023 spi_sdo_o SHALL be 0 outside SHIFT.

Reset
REQ-024 rstn_i low SHALL force at next edge: state IDLE, spi_csn_o=11, spi_clk_o=0, spi_sdo_o=0, gnt_o=00, tx_ready_o=00, rx_valid_o=00, rx_data_o=0, divider/bit counters 0, last-granted=1.
REQ-025 Reset mid-SHIFT SHALL abort the byte with no rx_valid pulse.

Structure
REQ-026 State encoding and SPI mode constants SHALL live in shared package spi_pkg.
REQ-027 SCK divider/bit counter SHALL be sub-module spi_clk_gen (tick outputs for rise/fall edges); all else in top.

Verification
REQ-028 CLK_DIV=2, sdi looped to sdo, r0 req sel=0, send 0xA5 -> csn=10, 8 sck pulses, rx_data 0xA5 after 32 cycles from accept, csn=11 after HOLD.
REQ-029 Both req asserted same cycle after reset -> gnt=01; r0 releases -> gnt=10 after HOLD+1 IDLE cycle, csn=01 (r1 sel=1).
REQ-030 MISO driven 0x3C pattern, r1 sends 0xFF with tx_valid held for 3 bytes -> three rx pulses 0x3C, 1-cycle gap each, csn low throughout.
REQ-031 r0 drops req after bit 3 of byte 0x81 -> byte completes, rx pulse, then HOLD; sel_i toggled mid-session has no effect on csn.
REQ-032 rstn_i low during bit 5 -> next cycle csn=11, sck=0, no rx pulse; assertions on REQ-022 checked for all tests.
